// File: rtl/mem_resp_router.sv
// Return-path router for the shared memory port.
// Every read accepted by the request mux leaves its requester tag (0 = fetch,
// 1 = load) in an in-order tag FIFO. Each memory response consumes the head tag
// and is steered, one cycle later, to either the fetch or the load/store stage.
module mem_resp_router #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_sel,
  output logic              issue_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [CNT_W-1:0]  outstanding,
  output logic              orphan_err
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  logic             tag_mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             head_tag;
  logic             empty;

  // Full/empty come from the occupancy counter; pointers alone cannot tell them apart.
  always_comb begin
    empty       = (count == '0);
    issue_ready = (count != FULL_CNT);
    push        = issue_valid && issue_ready;
    pop         = rsp_valid && !empty;
    head_tag    = tag_mem[rptr];
    outstanding = count;
  end

  // Tag storage: written at the write pointer on every accepted issue.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wptr] <= issue_sel;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + ONE_PTR;
      if (pop)  rptr <= rptr + ONE_PTR;
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Registered routing stage: steer the popped response by its head tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      ld_valid <= 1'b0;
      if_data  <= '0;
      ld_data  <= '0;
    end else begin
      if_valid <= pop && !head_tag;
      ld_valid <= pop && head_tag;
      if (pop && !head_tag) if_data <= rsp_data;
      if (pop && head_tag)  ld_data <= rsp_data;
    end
  end

  // Sticky flag for a response that has no outstanding read to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      orphan_err <= 1'b0;
    end else if (rsp_valid && empty) begin
      orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_resp_router.sv
// Directed testbench for mem_resp_router with hand-computed expectations.
module tb_mem_resp_router;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic              issue_sel;
  logic              issue_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic [CNT_W-1:0]  outstanding;
  logic              orphan_err;

  int errors = 0;
  int checks = 0;

  mem_resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_sel  (issue_sel),
    .issue_ready(issue_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .if_valid   (if_valid),
    .if_data    (if_data),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .outstanding(outstanding),
    .orphan_err (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sel);
    issue_valid = 1'b1;
    issue_sel   = sel;
    tick();
    issue_valid = 1'b0;
    issue_sel   = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    rsp_valid = 1'b1;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
    rsp_data  = '0;
  endtask

  task automatic expect_if(input string tag, input logic [31:0] d);
    check({tag, "_ifv"}, 32'(if_valid), 32'd1);
    check({tag, "_ldv"}, 32'(ld_valid), 32'd0);
    check({tag, "_ifd"}, if_data, d);
  endtask

  task automatic expect_ld(input string tag, input logic [31:0] d);
    check({tag, "_ifv"}, 32'(if_valid), 32'd0);
    check({tag, "_ldv"}, 32'(ld_valid), 32'd1);
    check({tag, "_ldd"}, ld_data, d);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_sel = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

    // 1. Reset then idle
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t1_out",    32'(outstanding), 32'd0);
    check("t1_ready",  32'(issue_ready), 32'd1);
    check("t1_ifv",    32'(if_valid), 32'd0);
    check("t1_ldv",    32'(ld_valid), 32'd0);
    check("t1_orphan", 32'(orphan_err), 32'd0);
    check("t1_ifd",    if_data, 32'd0);
    check("t1_ldd",    ld_data, 32'd0);

    // 2. Interleaved routing
    issue(1'b0); issue(1'b1); issue(1'b1); issue(1'b0);
    check("t2_out4", 32'(outstanding), 32'd4);
    respond(32'hA0); expect_if("t2_a0", 32'hA0);
    respond(32'hB1); expect_ld("t2_b1", 32'hB1);
    check("t2_ifhold", if_data, 32'hA0);
    respond(32'hC2); expect_ld("t2_c2", 32'hC2);
    respond(32'hD3); expect_if("t2_d3", 32'hD3);
    check("t2_ldhold", ld_data, 32'hC2);
    tick();
    check("t2_idle_ifv", 32'(if_valid), 32'd0);
    check("t2_idle_ldv", 32'(ld_valid), 32'd0);
    check("t2_out0",     32'(outstanding), 32'd0);

    // 3. Full, dropped issue, pointer wrap
    for (int i = 0; i < 4; i++) issue(1'b1);
    check("t3_ready", 32'(issue_ready), 32'd0);
    check("t3_out4",  32'(outstanding), 32'd4);
    issue(1'b0);
    check("t3_drop_out", 32'(outstanding), 32'd4);
    for (int i = 0; i < 4; i++) begin
      respond(32'h100 + 32'(i));
      expect_ld($sformatf("t3_r%0d", i), 32'h100 + 32'(i));
    end
    check("t3_out0",   32'(outstanding), 32'd0);
    check("t3_ready1", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      issue(1'b1);
      respond(32'h200 + 32'(i));
      expect_ld($sformatf("t3_w%0d", i), 32'h200 + 32'(i));
    end
    check("t3_ifhold", if_data, 32'hD3);
    check("t3_outw",   32'(outstanding), 32'd0);

    // 4. Simultaneous push and pop
    issue(1'b0); issue(1'b1);
    check("t4_out2", 32'(outstanding), 32'd2);
    issue_valid = 1'b1; issue_sel = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h55;
    tick();
    issue_valid = 1'b0; issue_sel = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    expect_if("t4_55", 32'h55);
    check("t4_out_same", 32'(outstanding), 32'd2);
    respond(32'h61); expect_ld("t4_61", 32'h61);
    respond(32'h62); expect_ld("t4_62", 32'h62);
    check("t4_out0", 32'(outstanding), 32'd0);

    // 5. Orphan response
    respond(32'h77);
    check("t5_ifv",    32'(if_valid), 32'd0);
    check("t5_ldv",    32'(ld_valid), 32'd0);
    check("t5_orphan", 32'(orphan_err), 32'd1);
    check("t5_ldd",    ld_data, 32'h62);
    check("t5_out",    32'(outstanding), 32'd0);
    issue(1'b0);
    respond(32'h88); expect_if("t5_88", 32'h88);
    check("t5_sticky", 32'(orphan_err), 32'd1);

    // 6. Reset mid-operation
    issue(1'b1); issue(1'b0); issue(1'b1);
    check("t6_out3", 32'(outstanding), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out0",   32'(outstanding), 32'd0);
    check("t6_ifv",    32'(if_valid), 32'd0);
    check("t6_ldv",    32'(ld_valid), 32'd0);
    check("t6_ifd",    if_data, 32'd0);
    check("t6_ldd",    ld_data, 32'd0);
    check("t6_orphan0", 32'(orphan_err), 32'd0);
    respond(32'h99);
    check("t6_orphan1", 32'(orphan_err), 32'd1);
    check("t6_ifv2",    32'(if_valid), 32'd0);
    check("t6_ldv2",    32'(ld_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_resp_router.md
Name: mem_resp_router

Overview:
- Return-path companion to the shared-memory request mux. The request side selects instruction fetch (sel=0) or data load (sel=1) onto the single memory port.
- This block records the sel of every issued read in an in-order tag FIFO.
- When each memory response arrives, it routes the response back to the requester that issued it: the fetch stage or the load/store stage.
- It sits between the unified memory and the IF/MEM pipeline stages.

Parameters:
- DATA_W, 32, response data width.
- DEPTH, 4, maximum outstanding reads (tag FIFO entries); power of 2, >=2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  the memory port accepts a read this cycle.
- issue_sel  input  1  requester of that read: 0 = instruction fetch, 1 = data load.
- issue_ready  output  1  tag FIFO can take a tag; the request mux must gate issues with it.
- rsp_valid  input  1  memory returns read data this cycle.
- rsp_data  input  DATA_W  memory read data.
- if_valid  output  1  one-cycle pulse: if_data is a fetch response.
- if_data  output  DATA_W  fetch response data.
- ld_valid  output  1  one-cycle pulse: ld_data is a load response.
- ld_data  output  DATA_W  load response data.
- outstanding  output  CNT_W  current FIFO occupancy.
- orphan_err  output  1  sticky: a response arrived with no outstanding tag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO emptied; read/write pointers = 0; outstanding = 0.
  - if_valid = ld_valid = 0; if_data = ld_data = 0; orphan_err = 0.
  - A reset mid-operation discards all pending tags. Responses arriving afterwards count as orphans.
- issue_ready = (outstanding != DEPTH). It is combinational from registered count only; a pop in the same cycle does not raise it.
- Push: issue_valid && issue_ready. issue_sel is written at wptr; wptr wraps modulo DEPTH.
- issue_valid while full: the tag is dropped, the FIFO is unchanged, and the event is not an error. Upstream must not issue while issue_ready=0.
- Pop: rsp_valid && (outstanding != 0). The head tag at rptr is consumed; rptr wraps modulo DEPTH.
- Routing is registered, latency 1 cycle from rsp_valid:
  - Head tag 0: next cycle if_valid=1 and if_data=rsp_data; ld_valid=0 and ld_data holds.
  - Head tag 1: next cycle ld_valid=1 and ld_data=rsp_data; if_valid=0 and if_data holds.
  - Both valids are 0 in every cycle not following a pop. Data registers hold their last routed value.
  - if_valid and ld_valid are never both 1.
- Simultaneous push and pop: both occur and outstanding is unchanged. This includes the full case only if push was legal, i.e. the count was below DEPTH.
- Empty FIFO and rsp_valid=1:
  - No pop and no valid pulse; orphan_err set to 1 and held until rst.
  - A push in the same cycle still happens. There is no bypass: a tag pushed this cycle cannot match this cycle's response.
- Order: strictly in-order. The memory returns responses in issue order; the block never reorders.
- Occupancy: outstanding = pushes - pops since reset. It never exceeds DEPTH and never underflows.
- Pointers are log2(DEPTH) bits wide; full/empty are decided by the counter, not by pointer comparison.

Test Plan:
1. Reset then idle: hold rst 2 cycles, then 5 idle cycles -> outstanding=0, issue_ready=1, all valids 0, orphan_err=0, if_data=ld_data=0.
2. Interleaved routing: issue sel 0,1,1,0, then responses 0xA0,0xB1,0xC2,0xD3 on consecutive cycles -> if_valid with 0xA0, ld_valid with 0xB1, ld_valid with 0xC2, if_valid with 0xD3. Each valid is one cycle after its rsp_valid. Finally outstanding=0.
3. Full/wrap: issue 4 reads (sel=1), check issue_ready=0 and outstanding=4. Issue a 5th -> dropped, count still 4. Return 4 responses, then issue/return 6 more -> pointers wrap and every response routes to ld, none to if.
4. Simultaneous push/pop: with 2 outstanding (sel 0,1), assert issue_valid(sel=1) and rsp_valid(0x55) in the same cycle -> if_valid with 0x55 next cycle, outstanding stays 2. The remaining order is 1,1.
5. Orphan: with the FIFO empty, pulse rsp_valid=1 with 0x77 -> no valid pulse, orphan_err=1 and remains 1 through later legal traffic until rst.
6. Reset mid-operation: 3 outstanding, assert rst for one cycle -> outstanding=0, valids 0, data regs 0. A subsequent rsp_valid sets orphan_err.
